seq_alu: RTL
============

# seq_alu

Parametrised multi-cycle ALU for the MIPS datapath; the successor to the combinational execute-stage ALU. Single-cycle ops (add/sub/logic/shift/compare) return in one cycle. Multiply, multiply-accumulate and optional unsigned divide run iteratively, one bit per cycle. A valid/ready handshake on both sides lets the pipeline stall on long ops.

## Interface
- WIDTH, 32, operand and result width (≥ 8, power of two)
- SHAMT_W, $clog2(WIDTH), shift-amount width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted when in_valid && in_ready
- op  in  4  operation code (see Operation)
- a, b  in  WIDTH  operands
- shamt  in  SHAMT_W  shift amount
- out_valid  out  1  result held valid
- out_ready  in  1  consumer takes result when out_valid && out_ready
- result  out  WIDTH  registered result
- zero  out  1  registered, result == 0
- busy  out  1  iterative op in progress

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0), 6 SLL b by shamt, 7 SRL, 8 SRA, 9 MUL (low WIDTH bits of a*b), 10 MAC (low WIDTH bits of a*b+b), 11 DIVU (quotient), 12 REMU (remainder); 13–15 give result 0.
- All arithmetic is modulo 2^WIDTH; no overflow flag. Operands are captured at accept; later input changes are ignored.
- FSM states: IDLE, MUL, DIV.
  - IDLE: accept → single-cycle op writes result, stays IDLE.
  - IDLE: MUL/MAC → MUL. Accumulator starts at 0 (MUL) or b (MAC); multiplier is a, multiplicand b.
  - IDLE: DIVU/REMU → DIV (restoring).
  - MUL/DIV: after WIDTH iterations, write result and return to IDLE.
- Divide by zero: no iteration. DIVU gives all ones, REMU gives a. Latency 1.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops sustain one per cycle.
- out_valid: set when a result is written. Cleared on out_ready unless a new result is written in the same cycle.
- result and zero are held stable while out_valid && !out_ready.
- busy = (state != IDLE).

## Timing
- Reset values:
  - in_ready 1 (IDLE, out empty)
  - out_valid 0, result 0, zero 0, busy 0
- Latency from accept edge to out_valid:
  - single-cycle ops: 1 cycle
  - MUL/MAC/DIVU/REMU: WIDTH+1 cycles
- Iterations proceed even if the output register is full. The final write waits in the last iteration state until the output register is free (out_valid == 0 or out_ready this cycle).
- Reset asserted mid-operation aborts immediately: state IDLE, outputs at reset values, no partial result emitted.
- Simultaneous drain and accept in IDLE is legal: old result leaves, new result appears next cycle.

## Configuration
- SEQ_ALU_DIV_EN
  - Defined: DIV state and divider datapath are built; DIVU/REMU behave as above.
  - Undefined: no divider logic; op 11/12 return 0 with latency 1, like the illegal codes.

## Structure
- Package seq_alu_pkg holds:
  - op-code localparams (OP_ADD … OP_REMU)
  - state enum typedef (ST_IDLE, ST_MUL, ST_DIV)
  - WIDTH-independent constants
- Sub-module seq_alu_iter: shared iteration counter plus shift/accumulate registers for MUL and DIV, controlled by the top FSM. Single-cycle ops stay in the top module.

## Test plan
- Reset, then ADD a=5 b=7 with out_ready=1 → out_valid one cycle after accept, result=12, zero=0; SUB 7−7 → result 0, zero=1.
- SLT a=0xFFFFFFFF b=1 → 1; SRA b=0x80000000 shamt=4 → 0xF8000000; SRL same → 0x08000000.
- MUL a=0x10001 b=0x10001 → 0x00020001 exactly 33 cycles after accept; in_ready low for that span, busy high; MAC a=3 b=4 → 16.
- DIVU a=100 b=7 → 14, REMU → 2, each at 33 cycles (with SEQ_ALU_DIV_EN). DIVU b=0 → 0xFFFFFFFF after 1 cycle. Without the macro, DIVU → 0 after 1 cycle.
- Backpressure: out_ready=0 after ADD → result held for 10 cycles, in_ready=0. Raise out_ready with a new ADD presented → both transfers occur on that edge.
- Assert rst at cycle 10 of a MUL → out_valid 0, busy 0, in_ready 1 immediately. Next op completes normally.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: op codes, FSM state type and helper decoders.
// The divider build option (SEQ_ALU_DIV_EN) is resolved in seq_alu and seq_alu_iter.
package seq_alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd8;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd9;
  localparam logic [OP_W-1:0] OP_MAC  = 4'd10;
  localparam logic [OP_W-1:0] OP_DIVU = 4'd11;
  localparam logic [OP_W-1:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_t;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MAC);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared bit-serial engine for seq_alu: down-counter plus shift/accumulate registers,
// used as shift-add multiplier or (with SEQ_ALU_DIV_EN) restoring divider.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, opd_q, shf_q;
  logic [WIDTH-1:0] acc_d, opd_d, shf_d;
  logic             step;
`ifdef SEQ_ALU_DIV_EN
  logic             div_q, quo_q;
  logic [WIDTH:0]   rem_sh, rem_sub;
`endif

  // The final iteration is held off while the output register is full, so res
  // (the post-step value) stays stable until the top can write it.
  assign last = (cnt_q == CNT_W'(1));
  assign step = (cnt_q != '0) && !(last && hold);

  always_comb begin
    acc_d = shf_q[0] ? acc_q + opd_q : acc_q;
    opd_d = opd_q << 1;
    shf_d = shf_q >> 1;
`ifdef SEQ_ALU_DIV_EN
    rem_sh  = {acc_q, shf_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opd_q};
    if (div_q) begin
      acc_d = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
      opd_d = opd_q;
      shf_d = {shf_q[WIDTH-2:0], ~rem_sub[WIDTH]};
    end
`endif
  end

`ifdef SEQ_ALU_DIV_EN
  assign res = (div_q && quo_q) ? shf_d : acc_d;
`else
  assign res = acc_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      shf_q <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= 1'b0;
      quo_q <= 1'b0;
`endif
    end else if (start) begin
      cnt_q <= CNT_W'(WIDTH);
      acc_q <= (op == OP_MAC) ? b : '0;
      opd_q <= b;
      shf_q <= a;
`ifdef SEQ_ALU_DIV_EN
      div_q <= is_div_op(op);
      quo_q <= (op == OP_DIVU);
`endif
    end else if (step) begin
      cnt_q <= cnt_q - CNT_W'(1);
      acc_q <= acc_d;
      opd_q <= opd_d;
      shf_q <= shf_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides; single-cycle ops computed here,
// MUL/MAC (and DIVU/REMU when SEQ_ALU_DIV_EN is defined) run in seq_alu_iter.
//
// state   | meaning
// ST_IDLE | ready for a new op; single-cycle ops complete from here
// ST_MUL  | multiply / multiply-accumulate iterating
// ST_DIV  | restoring divide iterating
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy
);

  state_t           state_q, state_d;
  logic             out_free, accept, wr_en, iter_start, iter_last;
  logic [WIDTH-1:0] wr_data, alu_res, iter_res;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_q == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
`ifdef SEQ_ALU_DIV_EN
      // Only selected for a zero divisor; non-zero divisors go to the iterator.
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = a;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_data    = alu_res;
    iter_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul_op(op)) begin
            iter_start = 1'b1;
            state_d    = ST_MUL;
          end
`ifdef SEQ_ALU_DIV_EN
          else if (is_div_op(op) && (b != '0)) begin
            iter_start = 1'b1;
            state_d    = ST_DIV;
          end
`endif
          else begin
            wr_en = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_last && out_free) begin
          wr_en   = 1'b1;
          wr_data = iter_res;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        out_valid <= 1'b1;
        result    <= wr_data;
        zero      <= (wr_data == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (iter_start),
    .hold  (!out_free),
    .op    (op),
    .a     (a),
    .b     (b),
    .last  (iter_last),
    .res   (iter_res)
  );

endmodule
